input_sync_debounce: RTL and testbench

//  Multi-channel front end for asynchronous board inputs (paddle/start buttons, switches) into one clock domain.
//  Per channel: SYNC_STAGES-deep metastability synchroniser, counter-based debounce filter,

---
 rtl/input_sync_debounce.sv | 92 +++++++++
 tb/tb_input_sync_debounce.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/input_sync_debounce.sv
// Multi-channel input front end: metastability synchroniser, counter debounce,
// registered rise/fall pulses and a toggle latch per channel.
module input_sync_debounce #(
  parameter int                     CHANNELS        = 4,
  parameter int                     SYNC_STAGES     = 2,
  parameter int                     DEBOUNCE_CYCLES = 500000,
  parameter logic [CHANNELS-1:0]    RESET_LEVEL     = '0
) (
  input  logic                i_clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] i_async,
  output logic [CHANNELS-1:0] o_level,
  output logic [CHANNELS-1:0] o_rise,
  output logic [CHANNELS-1:0] o_fall,
  output logic [CHANNELS-1:0] o_toggle,
  output logic                o_any_event
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0][CHANNELS-1:0] sync_q;
  logic [CHANNELS-1:0]                  s;
  logic [CNT_W-1:0]                     cnt   [CHANNELS];
  logic [CNT_W-1:0]                     cnt_d [CHANNELS];
  logic [CHANNELS-1:0]                  level_d;
  logic [CHANNELS-1:0]                  rise_d;
  logic [CHANNELS-1:0]                  fall_d;
  logic [CHANNELS-1:0]                  toggle_d;

  // Plain flop chain; no logic between stages so each stage can resolve.
  always_ff @(posedge i_clk or negedge rst) begin
    if (!rst) begin
      sync_q <= {SYNC_STAGES{RESET_LEVEL}};
    end else begin
      sync_q[0] <= i_async;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // Any cycle where the input agrees with the accepted level restarts the count,
  // so only an unbroken run of DEBOUNCE_CYCLES mismatches is accepted.
  always_comb begin
    level_d  = o_level;
    rise_d   = '0;
    fall_d   = '0;
    toggle_d = o_toggle;
    cnt_d    = cnt;
    for (int i = 0; i < CHANNELS; i++) begin
      if (s[i] == o_level[i]) begin
        cnt_d[i] = '0;
      end else if (cnt[i] == CNT_LAST) begin
        cnt_d[i]   = '0;
        level_d[i] = s[i];
        rise_d[i]  = s[i];
        fall_d[i]  = ~s[i];
        if (s[i]) begin
          toggle_d[i] = ~o_toggle[i];
        end
      end else begin
        cnt_d[i] = cnt[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        cnt[i] <= '0;
      end
      o_level     <= RESET_LEVEL;
      o_toggle    <= RESET_LEVEL;
      o_rise      <= '0;
      o_fall      <= '0;
      o_any_event <= 1'b0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        cnt[i] <= cnt_d[i];
      end
      o_level     <= level_d;
      o_toggle    <= toggle_d;
      o_rise      <= rise_d;
      o_fall      <= fall_d;
      o_any_event <= |(rise_d | fall_d);
    end
  end

endmodule

// File: tb/tb_input_sync_debounce.sv
// Directed bench for input_sync_debounce with 2 channels, 2 sync stages and a
// 4-cycle debounce window; accepted edges appear 5 clocks after first sample.
module tb_input_sync_debounce;

  logic       i_clk;
  logic       rst;
  logic [1:0] i_async;
  logic [1:0] o_level;
  logic [1:0] o_rise;
  logic [1:0] o_fall;
  logic [1:0] o_toggle;
  logic       o_any_event;

  int check_count;
  int error_count;

  input_sync_debounce #(
    .CHANNELS       (2),
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4),
    .RESET_LEVEL    (2'b00)
  ) dut (
    .i_clk      (i_clk),
    .rst        (rst),
    .i_async    (i_async),
    .o_level    (o_level),
    .o_rise     (o_rise),
    .o_fall     (o_fall),
    .o_toggle   (o_toggle),
    .o_any_event(o_any_event)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_count++;
    if (got !== exp) begin
      error_count++;
      $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance past the next rising edge so outputs are sampled away from it.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [1:0] val);
    i_async = val;
  endtask

  task automatic applyReset(input logic [1:0] val);
    i_async = val;
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic checkAll(input string tag, input logic [1:0] lvl, input logic [1:0] rise,
                          input logic [1:0] fall, input logic [1:0] tog, input logic any);
    checkOutput({tag, "_level"},  32'(o_level),     32'(lvl));
    checkOutput({tag, "_rise"},   32'(o_rise),      32'(rise));
    checkOutput({tag, "_fall"},   32'(o_fall),      32'(fall));
    checkOutput({tag, "_toggle"}, 32'(o_toggle),    32'(tog));
    checkOutput({tag, "_any"},    32'(o_any_event), 32'(any));
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [4:0] bounce;
    check_count = 0;
    error_count = 0;
    rst     = 1'b0;
    i_async = 2'b11;

    // 1: reset held with inputs high, then release; accepted 5 edges after first sample
    tick();
    tick();
    checkAll("t1_in_reset", 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
    rst = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      checkAll("t1_wait", 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
    end
    tick();
    checkAll("t1_accept", 2'b11, 2'b11, 2'b00, 2'b11, 1'b1);
    tick();
    checkAll("t1_after", 2'b11, 2'b00, 2'b00, 2'b11, 1'b0);

    // 2: clean rise on ch0 from a fresh reset
    applyReset(2'b00);
    tick();
    tick();
    checkAll("t2_idle", 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
    applyStimulus(2'b01);
    for (int k = 1; k <= 5; k++) begin
      tick();
      checkAll("t2_wait", 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
    end
    tick();
    checkAll("t2_accept", 2'b01, 2'b01, 2'b00, 2'b01, 1'b1);
    tick();
    checkAll("t2_after", 2'b01, 2'b00, 2'b00, 2'b01, 1'b0);

    // bring ch0 back low; the fall must not touch the toggle
    applyStimulus(2'b00);
    for (int k = 1; k <= 5; k++) tick();
    tick();
    checkAll("t2_fall", 2'b00, 2'b00, 2'b01, 2'b01, 1'b1);
    tick();
    tick();

    // 3: ch0 high for only 3 cycles is rejected
    applyStimulus(2'b01);
    for (int k = 0; k < 3; k++) begin
      tick();
      checkAll("t3_short_hi", 2'b00, 2'b00, 2'b00, 2'b01, 1'b0);
    end
    applyStimulus(2'b00);
    for (int k = 0; k < 7; k++) begin
      tick();
      checkAll("t3_short_lo", 2'b00, 2'b00, 2'b00, 2'b01, 1'b0);
    end

    // 4: bounce 1,0,1,1,0 then steady 1 yields exactly one rise
    bounce = 5'b01101;
    for (int k = 0; k < 5; k++) begin
      applyStimulus({1'b0, bounce[k]});
      tick();
      checkOutput("t4_bounce_rise", 32'(o_rise), 32'd0);
    end
    applyStimulus(2'b01);
    for (int k = 1; k <= 5; k++) begin
      tick();
      checkAll("t4_wait", 2'b00, 2'b00, 2'b00, 2'b01, 1'b0);
    end
    tick();
    checkAll("t4_accept", 2'b01, 2'b01, 2'b00, 2'b00, 1'b1);
    for (int k = 0; k < 6; k++) begin
      tick();
      checkAll("t4_after", 2'b01, 2'b00, 2'b00, 2'b00, 1'b0);
    end

    // 5: ch0 rises while ch1 falls on the same edge (set up ch0=0, ch1=1 first)
    applyStimulus(2'b10);
    for (int k = 1; k <= 5; k++) tick();
    tick();
    checkAll("t5_setup", 2'b10, 2'b10, 2'b01, 2'b10, 1'b1);
    tick();
    tick();
    applyStimulus(2'b01);
    for (int k = 1; k <= 5; k++) begin
      tick();
      checkAll("t5_wait", 2'b10, 2'b00, 2'b00, 2'b10, 1'b0);
    end
    tick();
    checkAll("t5_accept", 2'b01, 2'b01, 2'b10, 2'b11, 1'b1);
    tick();
    checkAll("t5_after", 2'b01, 2'b00, 2'b00, 2'b11, 1'b0);

    // 6: reset mid-count discards the partial count; the rise is re-debounced once
    applyReset(2'b00);
    tick();
    tick();
    applyStimulus(2'b01);
    for (int k = 0; k < 4; k++) tick();
    rst = 1'b0;
    #1;
    checkAll("t6_in_reset", 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
    tick();
    rst = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      checkAll("t6_wait", 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
    end
    tick();
    checkAll("t6_accept", 2'b01, 2'b01, 2'b00, 2'b01, 1'b1);
    for (int k = 0; k < 6; k++) begin
      tick();
      checkAll("t6_after", 2'b01, 2'b00, 2'b00, 2'b01, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", check_count, error_count);
    $finish;
  end

endmodule
